// File: rtl/aes_shift_rows_pipe.sv
// Registered ShiftRows / InvShiftRows stage for Rijndael (NB = 4, 6, 8) with a
// 2-entry valid/ready elastic buffer (head register drives out_*, plus a skid register).
module aes_shift_rows_pipe #(
    parameter  int NB = 4,
    localparam int W  = 32 * NB
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_encrypt,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_encrypt
);

    if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
        $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_t;

    buf_state_t   state;
    logic [W-1:0] head_data;
    logic         head_enc;
    logic [W-1:0] skid_data;
    logic         skid_enc;
    logic [W-1:0] shifted;
    logic         push;
    logic         pop;

    // Rijndael row offsets; the 256-bit block uses a wider spread for rows 2 and 3.
    function automatic int row_offset(input int r);
        case (r)
            0:       return 0;
            1:       return 1;
            2:       return (NB == 8) ? 3 : 2;
            default: return (NB == 8) ? 4 : 3;
        endcase
    endfunction

    // Byte 4c+r is state element (row r, column c); byte 0 sits at the MSB.
    function automatic logic [W-1:0] permute(input logic [W-1:0] d, input logic enc);
        logic [W-1:0] res;
        int           src;
        res = '0;
        for (int c = 0; c < NB; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = enc ? (c + row_offset(r)) % NB
                          : (c - row_offset(r) + NB) % NB;
                res[W-1-8*(4*c+r) -: 8] = d[W-1-8*(4*src+r) -: 8];
            end
        end
        return res;
    endfunction

    assign shifted = permute(in_data, in_encrypt);

    // Handshake flags decode registered state only, so in_ready never sees out_ready.
    assign out_valid   = (state != EMPTY);
    assign in_ready    = (state != FULL);
    assign out_data    = head_data;
    assign out_encrypt = head_enc;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // NOTE: both data registers are reset so out_data is zero after rst; this is
    // only two words, not a memory array, so the reset costs nothing meaningful.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            head_data <= '0;
            head_enc  <= 1'b0;
            skid_data <= '0;
            skid_enc  <= 1'b0;
        end else if (flush) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        head_data <= shifted;
                        head_enc  <= in_encrypt;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        skid_data <= shifted;
                        skid_enc  <= in_encrypt;
                        state     <= FULL;
                    end else if (push && pop) begin
                        head_data <= shifted;
                        head_enc  <= in_encrypt;
                    end else if (pop) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head_data <= skid_data;
                        head_enc  <= skid_enc;
                        state     <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Directed bench for aes_shift_rows_pipe: NB=4 and NB=8 vectors, backpressure,
// flush, mid-stream reset and an alternating-direction stream with a byte-rotation model.
module tb_aes_shift_rows_pipe;

    localparam logic [127:0] V_ID  = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] V_ENC = 128'h00050A0F04090E03080D02070C01060B;
    localparam logic [127:0] V_DEC = 128'h000D0A0704010E0B0805020F0C090603;
    localparam logic [255:0] V8_ID =
        256'h00010203_04050607_08090A0B_0C0D0E0F_10111213_14151617_18191A1B_1C1D1E1F;
    localparam logic [255:0] V8_ENC =
        256'h00050E13_04091217_080D161B_0C111A1F_10151E03_14190207_181D060B_1C010A0F;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush, in_valid, in_encrypt, out_ready;
    logic         in_ready, out_valid, out_encrypt;
    logic [127:0] in_data, out_data;
    logic         flush8, in_valid8, in_encrypt8, out_ready8;
    logic         in_ready8, out_valid8, out_encrypt8;
    logic [255:0] in_data8, out_data8;

    int total = 0;
    int bad   = 0;

    aes_shift_rows_pipe #(.NB(4)) dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_encrypt(in_encrypt), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_encrypt(out_encrypt)
    );

    aes_shift_rows_pipe #(.NB(8)) dut8 (
        .clk(clk), .rst(rst), .flush(flush8),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_encrypt(in_encrypt8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .out_encrypt(out_encrypt8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: rotate each row of the 4x4 state as a byte list.
    function automatic logic [127:0] model4(input logic [127:0] d, input logic enc);
        logic [7:0]   b[16];
        logic [7:0]   row[4];
        logic [7:0]   t;
        logic [127:0] res;
        for (int k = 0; k < 16; k++) b[k] = d[127-8*k -: 8];
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) row[c] = b[4*c+r];
            for (int s = 0; s < r; s++) begin
                if (enc) begin
                    t = row[0]; row[0] = row[1]; row[1] = row[2]; row[2] = row[3]; row[3] = t;
                end else begin
                    t = row[3]; row[3] = row[2]; row[2] = row[1]; row[1] = row[0]; row[0] = t;
                end
            end
            for (int c = 0; c < 4; c++) b[4*c+r] = row[c];
        end
        for (int k = 0; k < 16; k++) res[127-8*k -: 8] = b[k];
        return res;
    endfunction

    logic [128:0] q[$];
    logic [128:0] exp_e;
    logic [127:0] cur_data;
    int           sent, got;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_encrypt = 1'b0; in_data = '0; out_ready = 1'b0;
        flush8 = 1'b0; in_valid8 = 1'b0; in_encrypt8 = 1'b0; in_data8 = '0; out_ready8 = 1'b0;
        tick(); tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
        check("rst_out_encrypt", out_encrypt, 0);
        check("rst_out_data8", out_data8, 0);
        rst = 1'b0;

        // NB=4 encrypt, decrypt and round trip back-to-back at full throughput.
        in_valid = 1'b1; in_encrypt = 1'b1; in_data = V_ID; out_ready = 1'b1;
        tick();
        check("enc4_valid", out_valid, 1);
        check("enc4_data", out_data, V_ENC);
        check("enc4_tag", out_encrypt, 1);
        check("enc4_in_ready", in_ready, 1);
        in_encrypt = 1'b0;
        tick();
        check("dec4_valid", out_valid, 1);
        check("dec4_data", out_data, V_DEC);
        check("dec4_tag", out_encrypt, 0);
        in_data = V_ENC;
        tick();
        check("rt4_data", out_data, V_ID);
        in_valid = 1'b0;
        tick();
        check("drain4_valid", out_valid, 0);

        // NB=8 encrypt then decrypt of the result.
        in_valid8 = 1'b1; in_encrypt8 = 1'b1; in_data8 = V8_ID; out_ready8 = 1'b1;
        tick();
        check("enc8_valid", out_valid8, 1);
        check("enc8_data", out_data8, V8_ENC);
        check("enc8_tag", out_encrypt8, 1);
        in_encrypt8 = 1'b0; in_data8 = V8_ENC;
        tick();
        check("rt8_data", out_data8, V8_ID);
        check("rt8_tag", out_encrypt8, 0);
        in_valid8 = 1'b0;
        tick();
        check("drain8_valid", out_valid8, 0);

        // Backpressure: A=enc(ID), B=dec(ID), C=dec(ENC)=ID with out_ready low.
        out_ready = 1'b0;
        in_valid = 1'b1; in_encrypt = 1'b1; in_data = V_ID;
        tick();
        check("bp_a_in_ready", in_ready, 1);
        check("bp_a_valid", out_valid, 1);
        in_encrypt = 1'b0;
        tick();
        check("bp_b_in_ready", in_ready, 0);
        in_data = V_ENC;
        tick();
        check("bp_c_held", in_ready, 0);
        check("bp_a_stable", out_data, V_ENC);
        check("bp_a_tag", out_encrypt, 1);
        out_ready = 1'b1;
        tick();
        check("bp_b_data", out_data, V_DEC);
        check("bp_b_tag", out_encrypt, 0);
        check("bp_b_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_c_data", out_data, V_ID);
        check("bp_c_valid", out_valid, 1);
        tick();
        check("bp_empty", out_valid, 0);

        // Flush with both entries occupied and in_valid asserted.
        out_ready = 1'b0; in_valid = 1'b1; in_encrypt = 1'b1; in_data = V_ID;
        tick(); tick();
        check("fl_full", in_ready, 0);
        flush = 1'b1; in_data = V_DEC;
        tick();
        check("fl_full_valid", out_valid, 0);
        check("fl_full_ready", in_ready, 1);
        // Flush in ONE while a push would otherwise be accepted.
        flush = 1'b0;
        tick();
        check("fl_one_setup", out_valid, 1);
        flush = 1'b1; in_data = V_ENC;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("fl_one_valid", out_valid, 0);
        tick();
        check("fl_dropped", out_valid, 0);

        // Asynchronous reset in the middle of a transfer.
        in_valid = 1'b1; in_encrypt = 1'b1; in_data = V_ID; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check("mr_setup", out_data, V_ENC);
        rst = 1'b1;
        #1;
        check("mr_out_valid", out_valid, 0);
        check("mr_out_data", out_data, 0);
        check("mr_in_ready", in_ready, 1);
        tick();
        rst = 1'b0;

        // Alternating direction stream with random backpressure.
        sent = 0; got = 0;
        cur_data = {$urandom, $urandom, $urandom, $urandom};
        for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
            in_valid   = (sent < 16);
            in_data    = cur_data;
            in_encrypt = (sent % 2 == 0);
            out_ready  = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("rand_extra", out_valid, 0);
                end else begin
                    exp_e = q.pop_front();
                    check("rand_data", out_data, exp_e[127:0]);
                    check("rand_tag", out_encrypt, exp_e[128]);
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                q.push_back({in_encrypt, model4(in_data, in_encrypt)});
                sent++;
                cur_data = {$urandom, $urandom, $urandom, $urandom};
            end
            tick();
        end
        in_valid = 1'b0;
        check("rand_count", got, 16);
        check("rand_leftover", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
